// File: rtl/video_capture_ctrl.sv
// rtl/video_capture_ctrl.sv - frame-capture sequencer gating the video2bmp enable
// Optional geometry checker enabled by defining VIDEO_CAPTURE_GEOM_CHECK_EN.
module video_capture_ctrl #(
   parameter int   SKIP_FRAMES    = 1,
   parameter int   CAPTURE_FRAMES = 2,
   parameter logic VS_POL         = 1'b1,
   parameter int   EXP_WIDTH      = 1536,
   parameter int   EXP_HEIGHT     = 768
) (
   input  logic        pclk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic        link_i,
   input  logic        vs_i,
   input  logic        hs_i,
   input  logic        de_i,
   output logic        en_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] frame_cnt_o,
   output logic        err_o
);
   typedef enum logic [2:0] {IDLE, WAIT_VS, SKIP, CAPTURE, DONE} state_t;

   state_t      state, state_n;
   logic        vs_d;
   logic        vs_edge;
   logic        start_ok;
   logic [7:0]  skip_cnt;
   logic [15:0] frame_inc;
   logic        unused_inputs;

   assign vs_edge       = (vs_i == VS_POL) && (vs_d != VS_POL);
   assign start_ok      = start_i && !abort_i && (state == IDLE || state == DONE);
   assign frame_inc     = (frame_cnt_o == 16'hFFFF) ? frame_cnt_o : frame_cnt_o + 16'd1;
   assign unused_inputs = ^{hs_i, link_i, de_i};

   always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (abort_i) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE, DONE: if (start_i) state_n = (CAPTURE_FRAMES == 0) ? DONE : WAIT_VS;
            WAIT_VS:    if (vs_edge) state_n = (SKIP_FRAMES > 0) ? SKIP : CAPTURE;
            SKIP:       if (vs_edge && skip_cnt == 8'(SKIP_FRAMES)) state_n = CAPTURE;
            CAPTURE:    if (vs_edge && frame_inc == 16'(CAPTURE_FRAMES)) state_n = DONE;
            default:    state_n = IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vs_d        <= !VS_POL;
         skip_cnt    <= 8'd0;
         frame_cnt_o <= 16'd0;
         done_o      <= 1'b0;
         en_o        <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         vs_d   <= vs_i;
         en_o   <= (state_n == CAPTURE);
         busy_o <= (state_n == WAIT_VS) || (state_n == SKIP) || (state_n == CAPTURE);
         if (start_ok) begin
            skip_cnt    <= 8'd0;
            frame_cnt_o <= 16'd0;
            done_o      <= (CAPTURE_FRAMES == 0);
         end else if (!abort_i && vs_edge) begin
            case (state)
               WAIT_VS: skip_cnt <= 8'd1;
               SKIP:    if (skip_cnt != 8'hFF) skip_cnt <= skip_cnt + 8'd1;
               CAPTURE: begin
                  frame_cnt_o <= frame_inc;
                  if (frame_inc == 16'(CAPTURE_FRAMES)) done_o <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef VIDEO_CAPTURE_GEOM_CHECK_EN
   logic [15:0] pix_cnt;
   logic [15:0] line_cnt;
   logic [16:0] pix_sum;
   logic        de_d;

   assign pix_sum = {1'b0, pix_cnt} + {15'd0, link_i, !link_i};

   // Counters only run while capturing, so every checked frame starts from zero.
   always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pix_cnt  <= 16'd0;
         line_cnt <= 16'd0;
         de_d     <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         de_d <= de_i;
         if (start_ok) err_o <= 1'b0;
         if (state != CAPTURE) begin
            pix_cnt  <= 16'd0;
            line_cnt <= 16'd0;
         end else begin
            if (de_i) pix_cnt <= pix_sum[16] ? 16'hFFFF : pix_sum[15:0];
            if (de_d && !de_i) begin
               if (pix_cnt != 16'(EXP_WIDTH)) err_o <= 1'b1;
               pix_cnt  <= 16'd0;
               line_cnt <= (line_cnt == 16'hFFFF) ? line_cnt : line_cnt + 16'd1;
            end
            if (vs_edge && !abort_i) begin
               if (line_cnt != 16'(EXP_HEIGHT)) err_o <= 1'b1;
               pix_cnt  <= 16'd0;
               line_cnt <= 16'd0;
            end
         end
      end
   end
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_video_capture_ctrl.sv
// tb/tb_video_capture_ctrl.sv - self-checking bench for video_capture_ctrl
module tb_video_capture_ctrl;
   localparam int W = 8;
   localparam int H = 4;
   localparam int SKP [3] = '{1, 0, 1};
   localparam int CAP [3] = '{2, 1, 0};
`ifdef VIDEO_CAPTURE_GEOM_CHECK_EN
   localparam bit GEOM = 1'b1;
`else
   localparam bit GEOM = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic link = 1'b0, vs = 1'b0, hs = 1'b0, de = 1'b0;
   logic        en_v   [3];
   logic        busy_v [3];
   logic        done_v [3];
   logic        err_v  [3];
   logic [15:0] fc_v   [3];

   int n_chk = 0, n_fail = 0;

   bit m_busy [3];
   bit m_done [3];
   bit m_err  [3];
   int m_k    [3];
   int m_fc   [3];
   bit m_vs_prev;
   bit last_frame_bad = 1'b1;

   always #5 clk = ~clk;

   video_capture_ctrl #(.SKIP_FRAMES(1), .CAPTURE_FRAMES(2), .VS_POL(1'b1), .EXP_WIDTH(W), .EXP_HEIGHT(H)) dut_a (
      .pclk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .link_i(link),
      .vs_i(vs), .hs_i(hs), .de_i(de), .en_o(en_v[0]), .busy_o(busy_v[0]),
      .done_o(done_v[0]), .frame_cnt_o(fc_v[0]), .err_o(err_v[0]));
   video_capture_ctrl #(.SKIP_FRAMES(0), .CAPTURE_FRAMES(1), .VS_POL(1'b1), .EXP_WIDTH(W), .EXP_HEIGHT(H)) dut_b (
      .pclk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .link_i(link),
      .vs_i(vs), .hs_i(hs), .de_i(de), .en_o(en_v[1]), .busy_o(busy_v[1]),
      .done_o(done_v[1]), .frame_cnt_o(fc_v[1]), .err_o(err_v[1]));
   video_capture_ctrl #(.SKIP_FRAMES(1), .CAPTURE_FRAMES(0), .VS_POL(1'b1), .EXP_WIDTH(W), .EXP_HEIGHT(H)) dut_c (
      .pclk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .link_i(link),
      .vs_i(vs), .hs_i(hs), .de_i(de), .en_o(en_v[2]), .busy_o(busy_v[2]),
      .done_o(done_v[2]), .frame_cnt_o(fc_v[2]), .err_o(err_v[2]));

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_busy[i] = 0; m_done[i] = 0; m_err[i] = 0; m_k[i] = 0; m_fc[i] = 0;
      end
      m_vs_prev = 0;
   endtask

   // Frame-level model: counts vs leading edges since the accepted start; capture covers
   // edges SKIP+1 .. SKIP+CAPTURE, completion arrives with edge SKIP+1+CAPTURE.
   task automatic model_update();
      bit edge_v;
      edge_v = vs && !m_vs_prev;
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (abort) begin
               m_busy[i] = 0;
            end else if (!m_busy[i] && start) begin
               m_k[i] = 0; m_fc[i] = 0; m_err[i] = 0;
               m_done[i] = (CAP[i] == 0);
               m_busy[i] = (CAP[i] != 0);
            end else if (m_busy[i] && edge_v) begin
               if (GEOM && m_k[i] >= SKP[i] + 1 && last_frame_bad) m_err[i] = 1;
               m_k[i]++;
               m_fc[i] = clampi(m_k[i] - SKP[i] - 1, 0, CAP[i]);
               if (m_k[i] >= SKP[i] + 1 + CAP[i]) begin
                  m_done[i] = 1;
                  m_busy[i] = 0;
               end
            end
         end
         m_vs_prev = vs;
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("en%0d", i),   int'(en_v[i]),   int'(m_busy[i] && m_k[i] >= SKP[i] + 1));
         check($sformatf("busy%0d", i), int'(busy_v[i]), int'(m_busy[i]));
         check($sformatf("done%0d", i), int'(done_v[i]), int'(m_done[i]));
         check($sformatf("fc%0d", i),   int'(fc_v[i]),   m_fc[i]);
         check($sformatf("err%0d", i),  int'(err_v[i]),  int'(m_err[i]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic cyc(input bit rnd);
      if (rnd) begin
         start = ($urandom_range(0, 59) == 0);
         abort = ($urandom_range(0, 199) == 0);
      end else begin
         start = 0;
         abort = 0;
      end
      step();
   endtask

   task automatic gen_frame(input int lines, input bit lnk, input bit rnd);
      link = lnk; hs = 0; de = 0;
      vs = 1; cyc(rnd); cyc(rnd); vs = 0;
      for (int l = 0; l < lines; l++) begin
         hs = 1; cyc(rnd); hs = 0; cyc(rnd);
         de = 1;
         for (int p = 0; p < (lnk ? W / 2 : W); p++) cyc(rnd);
         de = 0; cyc(rnd); cyc(rnd);
      end
      last_frame_bad = (lines != H);
      start = 0; abort = 0;
   endtask

   typedef struct {
      bit start, abort, vs;
      bit en, busy, done;
      int fc;
      bit done_c;
   } vec_t;
   vec_t tbl [19];

   initial begin
      tbl[0]  = '{1, 0, 1, 0, 1, 0, 0, 1};
      tbl[1]  = '{0, 0, 1, 0, 1, 0, 0, 1};
      tbl[2]  = '{0, 0, 0, 0, 1, 0, 0, 1};
      tbl[3]  = '{0, 0, 1, 0, 1, 0, 0, 1};
      tbl[4]  = '{0, 0, 0, 0, 1, 0, 0, 1};
      tbl[5]  = '{1, 0, 1, 1, 1, 0, 0, 1};
      tbl[6]  = '{0, 0, 0, 1, 1, 0, 0, 1};
      tbl[7]  = '{0, 0, 1, 1, 1, 0, 1, 1};
      tbl[8]  = '{0, 1, 0, 0, 0, 0, 1, 1};
      tbl[9]  = '{0, 0, 1, 0, 0, 0, 1, 1};
      tbl[10] = '{1, 0, 0, 0, 1, 0, 0, 1};
      tbl[11] = '{0, 0, 1, 0, 1, 0, 0, 1};
      tbl[12] = '{0, 0, 0, 0, 1, 0, 0, 1};
      tbl[13] = '{0, 0, 1, 1, 1, 0, 0, 1};
      tbl[14] = '{0, 0, 0, 1, 1, 0, 0, 1};
      tbl[15] = '{0, 0, 1, 1, 1, 0, 1, 1};
      tbl[16] = '{0, 0, 0, 1, 1, 0, 1, 1};
      tbl[17] = '{0, 0, 1, 0, 0, 1, 2, 1};
      tbl[18] = '{0, 0, 0, 0, 0, 1, 2, 1};

      model_reset();
      step();
      step();
      rst_n = 1;

      // Table phase: bare vsync toggles, no active video (frames count as malformed).
      last_frame_bad = 1;
      for (int i = 0; i < 19; i++) begin
         start = tbl[i].start; abort = tbl[i].abort; vs = tbl[i].vs;
         step();
         check($sformatf("tbl%0d_en", i),   int'(en_v[0]),   int'(tbl[i].en));
         check($sformatf("tbl%0d_busy", i), int'(busy_v[0]), int'(tbl[i].busy));
         check($sformatf("tbl%0d_done", i), int'(done_v[0]), int'(tbl[i].done));
         check($sformatf("tbl%0d_fc", i),   int'(fc_v[0]),   tbl[i].fc);
         check($sformatf("tbl%0d_donec", i), int'(done_v[2]), int'(tbl[i].done_c));
      end
      start = 0; abort = 0; vs = 0;
      step();

      // Four well-formed single-link frames after a start.
      start = 1; step(); start = 0;
      for (int f = 0; f < 4; f++) gen_frame(H, 0, 0);
      check("seq4_fc", int'(fc_v[0]), 2);
      check("seq4_done", int'(done_v[0]), 1);
      check("seq4_err", int'(err_v[0]), 0);

      // Dual-link frames with a one-line-short captured frame.
      start = 1; step(); start = 0;
      gen_frame(H, 1, 0);
      gen_frame(H - 1, 1, 0);
      gen_frame(H, 1, 0);
      gen_frame(H, 1, 0);
      check("short_err", int'(err_v[0]), int'(GEOM));
      check("short_done", int'(done_v[0]), 1);
      start = 1; step(); start = 0;
      check("short_err_cleared", int'(err_v[0]), 0);

      // Asynchronous reset while capturing.
      gen_frame(H, 0, 0);
      gen_frame(H, 0, 0);
      check("mid_capture_en", int'(en_v[0]), 1);
      @(negedge clk);
      rst_n = 0;
      #1;
      model_reset();
      compare_all();
      step();
      rst_n = 1;
      step();

      // Randomised start/abort over a stream of mostly well-formed frames.
      for (int f = 0; f < 40; f++)
         gen_frame(($urandom_range(0, 7) == 0) ? H - 1 : H, 1'($urandom_range(0, 1)), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/video_capture_ctrl.md
# video_capture_ctrl

Frame-capture sequencer for the image simulation framework. Watches the DUT video timing stream (`vs_i`/`hs_i`/`de_i`), skips a configurable number of warm-up frames after a start request, then drives the `video2bmp` enable for exactly `CAPTURE_FRAMES` whole frames and reports completion. Sits between the testbench control and the `monitor`/`video2bmp` instance, replacing a hand-driven `video2bmp_en`. An optional checker flags captured frames whose geometry differs from the configured BMP size.

## Interface
- `SKIP_FRAMES`, 1: frames discarded after start before capture begins (0..255).
- `CAPTURE_FRAMES`, 2: frames captured per start (0..65535); matches `BMP_OUTPUTED_NUMBER`.
- `VS_POL`, 1: active level of `vs_i`.
- `EXP_WIDTH`, 1536: expected pixels per line; must equal `BMP_OUTPUTED_WIDTH`.
- `EXP_HEIGHT`, 768: expected lines per frame; must equal `BMP_OUTPUTED_HEIGHT`.

- `pclk_i` in 1: pixel clock; all logic on its rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle start request; honoured only in IDLE or DONE.
- `abort_i` in 1: abandon the current sequence and return to IDLE.
- `link_i` in 1: 0 = single pixel per `de_i` cycle, 1 = dual pixel.
- `vs_i` in 1: vertical sync, synchronous to `pclk_i`.
- `hs_i` in 1: horizontal sync (pass-through observation only).
- `de_i` in 1: data valid.
- `en_o` out 1: enable to `video2bmp` `en_i`.
- `busy_o` out 1: high in WAIT_VS, SKIP, CAPTURE.
- `done_o` out 1: sticky completion flag.
- `frame_cnt_o` out 16: captured frames completed in current sequence.
- `err_o` out 1: sticky geometry mismatch flag.

## Operation
- Frame boundary = vs leading edge: `vs_i == VS_POL` while registered `vs_d != VS_POL`. `vs_d` resets to `!VS_POL`.
- States: IDLE, WAIT_VS, SKIP, CAPTURE, DONE.
- IDLE/DONE + `start_i` -> WAIT_VS; clears `done_o`, `err_o`, `frame_cnt_o`, skip counter. If `CAPTURE_FRAMES == 0`, go directly to DONE instead.
- WAIT_VS + edge -> SKIP if `SKIP_FRAMES > 0` (skip count = 1), else CAPTURE.
- SKIP + edge: if skip count == `SKIP_FRAMES` -> CAPTURE, else increment.
- CAPTURE + edge: `frame_cnt_o` += 1; if new value == `CAPTURE_FRAMES` -> DONE, else stay.
- `en_o` = 1 exactly in CAPTURE (registered). `done_o` set on entry to DONE, held until next `start_i`.
- `abort_i` in any state -> IDLE; `abort_i` beats `start_i` and any simultaneous edge. `done_o`, `frame_cnt_o`, `err_o` retain values on abort.
- `start_i` in WAIT_VS/SKIP/CAPTURE ignored.
- Edge in same cycle as `start_i`: start is accepted, edge is not counted (sequence waits for the next edge).
- Counters saturate, never wrap.

## Timing
- Reset: state IDLE, `en_o`=0, `busy_o`=0, `done_o`=0, `frame_cnt_o`=0, `err_o`=0.
- All outputs registered; state change and outputs update on the clock edge after the cycle in which the vs edge/start/abort is sampled (latency 1).
- `en_o` rises 1 cycle after the leading edge opening the first captured frame and falls 1 cycle after the leading edge closing the last one, so `video2bmp` sees both bounding vsyncs with `en_o`... high through the whole frame and low on the following one.
- `frame_cnt_o` and `done_o` update in the same cycle `en_o` falls.

## Configuration
- `VIDEO_CAPTURE_GEOM_CHECK_EN` defined: in CAPTURE, pixel counter adds 1 (`link_i`=0) or 2 (`link_i`=1) per `de_i` cycle; at `de_i` falling edge compares against `EXP_WIDTH` (mismatch sets `err_o`), clears, increments line counter; at each vs edge in CAPTURE compares line count against `EXP_HEIGHT`, then clears. `err_o` updates 1 cycle after the detecting cycle.
- Not defined: no counters synthesised, `err_o` tied 0.

## Test plan
- Reset mid-CAPTURE (`rst_n_i` low asynchronously) -> all outputs 0 immediately, IDLE after release; next `start_i` runs normally.
- Defaults, 4 frames of 1536x768 single-link, start before frame 0 -> frame 0 skipped, `en_o` high for frames 1-2, `frame_cnt_o`=2, `done_o`=1 one cycle after frame-3 vs edge, `err_o`=0.
- `SKIP_FRAMES`=0, `CAPTURE_FRAMES`=1, `link_i`=1 with 768 de cycles/line -> `en_o` for frame 0 only, `err_o`=0 (macro on).
- Frame with 767 lines during capture, macro on -> `err_o`=1 one cycle after closing vs edge, stays 1 until next `start_i`; macro off -> `err_o`=0.
- `abort_i` during CAPTURE after 1 frame -> `en_o`=0 next cycle, IDLE, `frame_cnt_o`=1, `done_o`=0; `start_i` with simultaneous vs edge -> that edge not counted.
- `CAPTURE_FRAMES`=0 -> `done_o`=1 one cycle after `start_i`, `en_o` never asserts; `start_i` while busy -> no effect.
